gpio_port: RTL and testbench

Parametrised general-purpose I/O port for the Yduck SoC, the successor to the fixed 16-bit `gpio_in`/`gpio_out` pair. It sits on the core's data bus as an 8-register peripheral. Per-bit features:
- direction control
- a 2-flop input synchroniser
- an optional digital debounce filter
- rising, falling or both-edge interrupt detection with write-1-to-clear status and a single level interrupt output.

---
 rtl/gpio_port.sv | 163 ++++++++++++++++
 tb/tb_gpio_port.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/gpio_port.sv
// gpio_port: parametrised GPIO peripheral with 8 bus registers,
// 2-flop input sync, optional debounce filter and edge interrupts.
// Optional debounce logic is built when GPIO_DEBOUNCE_EN is defined.
// Ports: clk, rst (async high); bus we/re/addr/wdata -> rdata (registered);
// pins gpio_in -> gpio_out/gpio_oe; irq = |(ISTAT & IEN).
module gpio_port #(
  parameter int DW   = 16,
  parameter int DB_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [2:0]    addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  input  logic [DW-1:0] gpio_in,
  output logic [DW-1:0] gpio_out,
  output logic [DW-1:0] gpio_oe,
  output logic          irq
);

  localparam logic [2:0] A_OUT   = 3'd0;
  localparam logic [2:0] A_DIR   = 3'd1;
  localparam logic [2:0] A_IN    = 3'd2;
  localparam logic [2:0] A_IEN   = 3'd3;
  localparam logic [2:0] A_IPOL  = 3'd4;
  localparam logic [2:0] A_IBOTH = 3'd5;
  localparam logic [2:0] A_ISTAT = 3'd6;
  localparam logic [2:0] A_DBCFG = 3'd7;

  logic [DW-1:0] out_q, out_d;
  logic [DW-1:0] dir_q, dir_d;
  logic [DW-1:0] ien_q, ien_d;
  logic [DW-1:0] ipol_q, ipol_d;
  logic [DW-1:0] iboth_q, iboth_d;
  logic [DW-1:0] istat_q, istat_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] sync1_q, sync2_q;
  logic [DW-1:0] f_q, f_d;
  logic [DW-1:0] evt, clr;
  logic [DW-1:0] rd_mux;

`ifdef GPIO_DEBOUNCE_EN
  logic [DB_W-1:0]          dbcfg_q, dbcfg_d;
  logic [DW-1:0][DB_W-1:0]  cnt_q, cnt_d;
`endif

  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    ien_d   = ien_q;
    ipol_d  = ipol_q;
    iboth_d = iboth_q;
`ifdef GPIO_DEBOUNCE_EN
    dbcfg_d = dbcfg_q;
`endif
    if (we) begin
      case (addr)
        A_OUT:   out_d   = wdata;
        A_DIR:   dir_d   = wdata;
        A_IEN:   ien_d   = wdata;
        A_IPOL:  ipol_d  = wdata;
        A_IBOTH: iboth_d = wdata;
`ifdef GPIO_DEBOUNCE_EN
        A_DBCFG: dbcfg_d = wdata[DB_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  // Filter and edge detect; an event is the cycle in which f changes.
  always_comb begin
    f_d = f_q;
    evt = '0;
`ifdef GPIO_DEBOUNCE_EN
    cnt_d = cnt_q;
`endif
    for (int i = 0; i < DW; i++) begin
`ifdef GPIO_DEBOUNCE_EN
      if (sync2_q[i] != f_q[i]) begin
        if (cnt_q[i] == dbcfg_q) begin
          f_d[i]   = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
`else
      f_d[i] = sync2_q[i];
`endif
      if (f_d[i] != f_q[i])
        evt[i] = iboth_q[i] | (ipol_q[i] == f_d[i]);
    end
  end

  // Set beats clear when both hit the same bit.
  assign clr     = (we && addr == A_ISTAT) ? wdata : '0;
  assign istat_d = (istat_q & ~clr) | evt;

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_OUT:   rd_mux = out_q;
      A_DIR:   rd_mux = dir_q;
      A_IN:    rd_mux = f_q;
      A_IEN:   rd_mux = ien_q;
      A_IPOL:  rd_mux = ipol_q;
      A_IBOTH: rd_mux = iboth_q;
      A_ISTAT: rd_mux = istat_q;
`ifdef GPIO_DEBOUNCE_EN
      A_DBCFG: rd_mux = DW'(dbcfg_q);
`endif
      default: rd_mux = '0;
    endcase
  end

  // Read captures pre-write state, so we+re returns the old value.
  assign rdata_d = re ? rd_mux : rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      dir_q   <= '0;
      ien_q   <= '0;
      ipol_q  <= '0;
      iboth_q <= '0;
      istat_q <= '0;
      rdata_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      f_q     <= '0;
`ifdef GPIO_DEBOUNCE_EN
      dbcfg_q <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      ien_q   <= ien_d;
      ipol_q  <= ipol_d;
      iboth_q <= iboth_d;
      istat_q <= istat_d;
      rdata_q <= rdata_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      f_q     <= f_d;
`ifdef GPIO_DEBOUNCE_EN
      dbcfg_q <= dbcfg_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign rdata    = rdata_q;
  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(istat_q & ien_q);

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed test of gpio_port register access,
// input latency, edge interrupts, W1C and the debounce filter.
module tb_gpio_port;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [2:0]    addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic [DW-1:0] gpio_in = '0;
  logic [DW-1:0] gpio_out;
  logic [DW-1:0] gpio_oe;
  logic          irq;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] v;

  gpio_port #(.DW(DW), .DB_W(4)) dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [DW-1:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [DW-1:0] d);
    re = 1'b1; addr = a;
    tick();
    re = 1'b0;
    d = rdata;
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    tick();
    chk("rst_out", gpio_out, 16'h0000);
    chk("rst_oe", gpio_oe, 16'h0000);
    chk("rst_irq", {15'd0, irq}, 16'h0000);
    chk("rst_rdata", rdata, 16'h0000);
    rd(3'd7, v); chk("rst_dbcfg", v, 16'h0000);

    wr(3'd0, 16'hFA1C);
    wr(3'd1, 16'h00FF);
    chk("gpio_out", gpio_out, 16'hFA1C);
    chk("gpio_oe", gpio_oe, 16'h00FF);
    rd(3'd0, v); chk("rd_out", v, 16'hFA1C);
    tick(3);
    chk("rdata_hold", rdata, 16'hFA1C);

    we = 1'b1; re = 1'b1; addr = 3'd0; wdata = 16'h1234;
    tick();
    we = 1'b0; re = 1'b0;
    chk("we_re_old", rdata, 16'hFA1C);
    rd(3'd0, v); chk("we_re_new", v, 16'h1234);

    // IN held on the bus: rdata lags f by one edge, so 4 edges total.
    re = 1'b1; addr = 3'd2; gpio_in = 16'hFA1C;
    tick(); chk("in_lat1", rdata, 16'h0000);
    tick(); chk("in_lat2", rdata, 16'h0000);
    tick(); chk("in_lat3", rdata, 16'h0000);
    tick(); chk("in_lat4", rdata, 16'hFA1C);
    re = 1'b0;

    // Default IPOL=0: the falls set ISTAT, IEN=0 masks irq.
    gpio_in = 16'h0000;
    tick(4);
    rd(3'd6, v); chk("fall_stat", v, 16'hFA1C);
    chk("ien_mask", {15'd0, irq}, 16'h0000);
    wr(3'd6, 16'hFFFF);
    rd(3'd6, v); chk("w1c_all", v, 16'h0000);

    wr(3'd3, 16'hFFFF);
    wr(3'd4, 16'h0001);
    wr(3'd5, 16'h0002);
    gpio_in = 16'h0007;
    tick(2); chk("irq_early", {15'd0, irq}, 16'h0000);
    tick(); chk("irq_rise", {15'd0, irq}, 16'h0001);
    rd(3'd6, v); chk("stat_rise", v, 16'h0003);
    wr(3'd6, 16'h0002);
    rd(3'd6, v); chk("w1c_b1", v, 16'h0001);
    gpio_in = 16'h0000;
    tick(3);
    rd(3'd6, v); chk("stat_fall", v, 16'h0007);
    wr(3'd6, 16'h0005);
    rd(3'd6, v); chk("w1c_0005", v, 16'h0002);
    chk("irq_kept", {15'd0, irq}, 16'h0001);
    wr(3'd6, 16'h0002);
    chk("irq_clr", {15'd0, irq}, 16'h0000);

    gpio_in = 16'h0002;
    tick(2);
    wr(3'd6, 16'h0002);
    rd(3'd6, v); chk("set_wins", v, 16'h0002);
    wr(3'd6, 16'h0002);
    rd(3'd6, v); chk("stat_zero", v, 16'h0000);

    wr(3'd4, 16'h0009);
`ifdef GPIO_DEBOUNCE_EN
    wr(3'd7, 16'h0004);
    rd(3'd7, v); chk("dbcfg_rd", v, 16'h0004);
    gpio_in = 16'h000A;
    tick(3);
    gpio_in = 16'h0002;
    tick(8);
    chk("glitch_irq", {15'd0, irq}, 16'h0000);
    rd(3'd2, v); chk("glitch_in", v, 16'h0002);
    rd(3'd6, v); chk("glitch_stat", v, 16'h0000);
    gpio_in = 16'h000A;
    tick(6); chk("db_edge6", {15'd0, irq}, 16'h0000);
    tick(); chk("db_edge7", {15'd0, irq}, 16'h0001);
    rd(3'd2, v); chk("db_in", v, 16'h000A);
    rd(3'd6, v); chk("db_stat", v, 16'h0008);
`else
    gpio_in = 16'h000A;
    tick(3);
    gpio_in = 16'h0002;
    chk("pulse_irq", {15'd0, irq}, 16'h0001);
    tick(4);
    rd(3'd2, v); chk("pulse_in", v, 16'h0002);
    rd(3'd6, v); chk("pulse_stat", v, 16'h0008);
    wr(3'd7, 16'h0004);
    rd(3'd7, v); chk("dbcfg_off", v, 16'h0000);
    rd(3'd6, v); chk("pulse_stat2", v, 16'h0008);
`endif

    // Asynchronous reset mid-cycle while irq is high.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_irq", {15'd0, irq}, 16'h0000);
    chk("arst_out", gpio_out, 16'h0000);
    chk("arst_oe", gpio_oe, 16'h0000);
    chk("arst_rdata", rdata, 16'h0000);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
